// File: rtl/dense_layer_seq.sv
// Sequential dense layer y = act(W*x + b) on one sign-magnitude MAC, valid/ready on both sides.
// Optional macro DENSE_SEQ_SAT_EN: clamp output magnitude instead of wrapping it.
module dense_layer_seq #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 10,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6,
  localparam int DEPTH  = N_OUT * (N_IN + 1),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITSIZE*N_IN-1:0]  x_in,
  input  logic                     act_sel,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [BITSIZE-1:0]       w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITSIZE*N_OUT-1:0] y_out,
  output logic                     busy
);

  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACC_W = 2*BITSIZE + $clog2(N_IN + 1);
  localparam int MW    = BITSIZE - 1;
  localparam int PW    = 2*MW;
  localparam logic [IW-1:0] LAST_I    = IW'(N_IN - 1);
  localparam logic [JW-1:0] LAST_J    = JW'(N_OUT - 1);
  localparam logic [AW-1:0] BIAS_BASE = AW'(N_OUT * N_IN);
  localparam logic [AW:0]   DEPTH_A   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [BITSIZE*N_IN-1:0]   x_q;
  logic                      act_q;
  logic [IW-1:0]             i_q;
  logic [JW-1:0]             j_q;
  logic [AW-1:0]             widx_q;
  logic [ACC_W-1:0]          acc_q;
  logic [BITSIZE-1:0]        y_q [N_OUT];
  logic [BITSIZE-1:0]        mem_q [DEPTH];
  logic                      in_ready_q, out_valid_q, busy_q;

  logic [BITSIZE-1:0]        x_cur_s, w_rd_s, b_rd_s, y_fin_s;
  logic [ACC_W-1:0]          prod_s, r_s, act_r_s;
  logic                      addr_ok_s;

  function automatic logic [ACC_W-1:0] sm_to_tc(input logic [BITSIZE-1:0] v);
    logic [ACC_W-1:0] mag;
    mag = ACC_W'(v[MW-1:0]);
    return v[BITSIZE-1] ? ({ACC_W{1'b0}} - mag) : mag;
  endfunction

  // Magnitude product is truncated toward zero before the sign is applied.
  function automatic logic [ACC_W-1:0] sm_mul(input logic [BITSIZE-1:0] a,
                                              input logic [BITSIZE-1:0] b);
    logic [PW-1:0]    full;
    logic [ACC_W-1:0] mag;
    full = PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
    mag  = ACC_W'(full >> FRAC);
    return (a[BITSIZE-1] ^ b[BITSIZE-1]) ? ({ACC_W{1'b0}} - mag) : mag;
  endfunction

  function automatic logic [BITSIZE-1:0] tc_to_sm(input logic [ACC_W-1:0] r);
    logic             neg;
    logic [ACC_W-1:0] mag;
    logic [MW-1:0]    m;
    neg = r[ACC_W-1];
    mag = neg ? ({ACC_W{1'b0}} - r) : r;
`ifdef DENSE_SEQ_SAT_EN
    m = (|mag[ACC_W-1:MW]) ? {MW{1'b1}} : mag[MW-1:0];
`else
    m = mag[MW-1:0];
`endif
    return {neg & (|m), m};
  endfunction

  // Datapath combinational terms: operand fetch, product, bias add, activation.
  always_comb begin
    x_cur_s   = x_q[BITSIZE*int'(i_q) +: BITSIZE];
    w_rd_s    = mem_q[widx_q];
    b_rd_s    = mem_q[BIAS_BASE + AW'(j_q)];
    prod_s    = sm_mul(x_cur_s, w_rd_s);
    r_s       = acc_q + sm_to_tc(b_rd_s);
    if (act_q && r_s[ACC_W-1]) begin
      act_r_s = {ACC_W{1'b0}};
    end else begin
      act_r_s = r_s;
    end
    y_fin_s   = tc_to_sm(act_r_s);
    addr_ok_s = ({1'b0, w_addr} < DEPTH_A);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = MAC; else state_d = IDLE;
      MAC:  if (i_q == LAST_I) state_d = FIN; else state_d = MAC;
      FIN:  if (j_q == LAST_J) state_d = DONE; else state_d = MAC;
      DONE: if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Operand latch, counters, accumulator and result vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      act_q  <= 1'b0;
      i_q    <= '0;
      j_q    <= '0;
      widx_q <= '0;
      acc_q  <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q    <= x_in;
            act_q  <= act_sel;
            i_q    <= '0;
            j_q    <= '0;
            widx_q <= '0;
            acc_q  <= '0;
          end
        end
        MAC: begin
          acc_q  <= acc_q + prod_s;
          i_q    <= i_q + 1'b1;
          widx_q <= widx_q + 1'b1;
        end
        FIN: begin
          y_q[j_q] <= y_fin_s;
          acc_q    <= '0;
          i_q      <= '0;
          if (j_q != LAST_J) j_q <= j_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Parameter memory has no reset; writes land only while idle and in range.
  always_ff @(posedge clk) begin
    if (w_we && (state_q == IDLE) && addr_ok_s) mem_q[w_addr] <= w_data;
  end

  // Output packing.
  always_comb begin
    y_out = '0;
    for (int k = 0; k < N_OUT; k++) y_out[BITSIZE*k +: BITSIZE] = y_q[k];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq at N_IN=N_OUT=2 (vector table plus corner sequences).
module tb_dense_layer_seq;
  localparam int BITSIZE = 16;
  localparam int N_IN    = 2;
  localparam int N_OUT   = 2;
  localparam int AW      = 3;
  localparam int LAT     = N_OUT * (N_IN + 1);
`ifdef DENSE_SEQ_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'hFFFF_7FFF;
`else
  localparam logic [31:0] OVF_EXP = 32'h0000_0400;
`endif

  logic                     clk, reset, in_valid, in_ready, act_sel, w_we;
  logic                     out_valid, out_ready, busy;
  logic [BITSIZE*N_IN-1:0]  x_in;
  logic [BITSIZE*N_OUT-1:0] y_out;
  logic [AW-1:0]            w_addr;
  logic [BITSIZE-1:0]       w_data;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    int          pset;
    logic [31:0] x;
    logic        act;
    logic [31:0] exp;
  } vec_t;
  vec_t        vecs[10];
  logic [15:0] psets[3][6];

  dense_layer_seq #(.BITSIZE(BITSIZE), .FRAC(10), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .act_sel(act_sel), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    chk(name, {31'd0, got}, {31'd0, want});
  endtask

  task automatic write_param(input int a, input logic [15:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = AW'(a); w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic load_params(input int p);
    for (int a = 0; a < 6; a++) write_param(a, psets[p][a]);
  endtask

  // Drive one vector for a single accepting edge, then scramble the inputs.
  task automatic send(input logic [31:0] x, input logic act, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b1; x_in = x; act_sel = act;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0; x_in = $urandom(); act_sel = ~act;
    chk1("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      chk1({name, "_timeout"}, out_valid, 1'b1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_y"}, y_out, sb_q.pop_front());
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1({name, "_ov_low"}, out_valid, 1'b0);
    chk1({name, "_ir_high"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cur;
    logic [31:0] held;
    psets[0] = '{16'h0400, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000};
    psets[1] = '{16'h0400, 16'h0400, 16'h0400, 16'h8400, 16'h8C00, 16'h0200};
    psets[2] = '{16'h3C00, 16'h0000, 16'h0000, 16'hA000, 16'h0000, 16'h0000};
    vecs[0] = '{0, 32'h8800_0400, 1'b0, 32'h8800_0400};
    vecs[1] = '{0, 32'h8200_0A00, 1'b1, 32'h0000_0A00};
    vecs[2] = '{0, 32'h0001_8000, 1'b0, 32'h0001_0000};
    vecs[3] = '{0, 32'h0000_8601, 1'b0, 32'h0000_8601};
    vecs[4] = '{1, 32'h0400_0400, 1'b0, 32'h0200_8400};
    vecs[5] = '{1, 32'h0400_0400, 1'b1, 32'h0200_0000};
    vecs[6] = '{1, 32'h8600_0200, 1'b0, 32'h0A00_9000};
    vecs[7] = '{1, 32'h0000_0001, 1'b0, 32'h0201_8BFF};
    vecs[8] = '{2, 32'h1000_3C00, 1'b0, OVF_EXP};
    vecs[9] = '{2, 32'h0001_0001, 1'b1, 32'h0000_000F};

    reset = 1'b1; in_valid = 1'b0; act_sel = 1'b0; x_in = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_y_out", y_out, 32'h0);
    @(negedge clk); reset = 1'b0;

    cur = -1;
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].pset != cur) begin
        load_params(vecs[v].pset);
        cur = vecs[v].pset;
      end
      send(vecs[v].x, vecs[v].act, vecs[v].exp);
      wait_result($sformatf("vec%0d", v), LAT);
      handshake($sformatf("vec%0d", v));
    end

    // Backpressure: result held 20 cycles while a new vector waits on in_valid.
    load_params(1);
    send(32'h0400_0400, 1'b0, 32'h0200_8400);
    wait_result("bp_first", LAT);
    held = 32'h0200_8400;
    @(negedge clk);
    in_valid = 1'b1; x_in = 32'h8600_0200; act_sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_y", y_out, held);
      chk1("bp_hold_ir", in_ready, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("bp_hs_ov", out_valid, 1'b0);
    chk1("bp_hs_ir", in_ready, 1'b1);
    chk1("bp_hs_busy", busy, 1'b0);
    sb_q.push_back(32'h0A00_9000);
    @(posedge clk); #1;
    chk1("bp_accept_busy", busy, 1'b1);
    in_valid = 1'b0; x_in = $urandom();
    wait_result("bp_second", LAT);
    handshake("bp_second");

    // Writes while busy or out of range must be dropped.
    send(32'h0400_0400, 1'b0, 32'h0200_8400);
    write_param(0, 16'h7C00);
    wait_result("gate_a", LAT - 1);
    handshake("gate_a");
    write_param(6, 16'h7C00);
    send(32'h0400_0400, 1'b0, 32'h0200_8400);
    wait_result("gate_b", LAT);
    handshake("gate_b");

    // Reset partway through the computation.
    @(negedge clk);
    in_valid = 1'b1; x_in = 32'h8600_0200; act_sel = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_y_out", y_out, 32'h0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk); reset = 1'b0;
    send(32'h8600_0200, 1'b0, 32'h0A00_9000);
    wait_result("after_rst", LAT);
    handshake("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
